// File: rtl/serial_pkg.sv
// Shared serial-link definitions: state encoding, clog2 helper, default bit period.
package serial_pkg;

   localparam int DEFAULT_BIT_CLKS = 5200;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARMED  = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_PARITY = 3'd4;
   localparam logic [2:0] ST_STOP   = 3'd5;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/serial_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module serial_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic m_clock,
   input  logic p_reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised async-serial receiver; parity check enabled by SERIAL_RX_PARITY_EN.
module serial_rx_param
   import serial_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BIT_CLKS   = DEFAULT_BIT_CLKS,
   parameter int MSB_FIRST  = 0,
   parameter int AUTO_REARM = 0
`ifdef SERIAL_RX_PARITY_EN
   ,parameter int PARITY_ODD = 0
`endif
) (
   input  logic                 m_clock,
   input  logic                 p_reset,
   input  logic                 RDX,
   input  logic                 launch,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 complete,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CW = clog2(BIT_CLKS);
   localparam int IW = clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_END = CW'(BIT_CLKS / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(BIT_CLKS - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
`ifdef SERIAL_RX_PARITY_EN
   localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
   localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

   logic                 rx_s;
   logic [2:0]           state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 cnt_run, tick, sample_bit, frame_end, par_ok;

   serial_sync2 #(.RST_VAL(1'b1)) u_sync (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .d       (RDX),
      .q       (rx_s)
   );

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (launch) state_nxt = ST_ARMED;
         ST_ARMED:  if (!rx_s) state_nxt = ST_START;
         ST_START:  if (tick) state_nxt = rx_s ? ST_ARMED : ST_DATA;
         ST_DATA:   if (tick && bit_idx == LAST_BIT) state_nxt = AFTER_DATA;
`ifdef SERIAL_RX_PARITY_EN
         ST_PARITY: if (tick) state_nxt = ST_STOP;
`endif
         ST_STOP:   if (tick) state_nxt = (AUTO_REARM != 0) ? ST_ARMED : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // tick marks the sample point of the current bit (mid-bit for START)
   always_comb begin
      busy       = 1'b1;
      cnt_run    = 1'b0;
      tick       = 1'b0;
      sample_bit = 1'b0;
      frame_end  = 1'b0;
      unique case (state)
         ST_IDLE:  busy = 1'b0;
         ST_ARMED: busy = 1'b1;
         ST_START: begin
            cnt_run = 1'b1;
            tick    = (cnt == HALF_END);
         end
         ST_DATA: begin
            cnt_run    = 1'b1;
            tick       = (cnt == BIT_END);
            sample_bit = tick;
         end
         ST_STOP: begin
            cnt_run   = 1'b1;
            tick      = (cnt == BIT_END);
            frame_end = tick;
         end
         default: begin
            cnt_run = 1'b1;
            tick    = (cnt == BIT_END);
         end
      endcase
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         DATA      <= '0;
         complete  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cnt <= (!cnt_run || tick) ? '0 : cnt + 1'b1;
         if (state == ST_START)
            bit_idx <= '0;
         else if (sample_bit)
            bit_idx <= bit_idx + 1'b1;
         if (sample_bit)
            shreg <= (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], rx_s}
                                      : {rx_s, shreg[DATA_BITS-1:1]};
         complete  <= frame_end & rx_s & par_ok;
         frame_err <= frame_end & ~rx_s;
         if (frame_end)
            DATA <= shreg;
      end
   end

`ifdef SERIAL_RX_PARITY_EN
   logic par_bit;

   assign par_ok = ((^shreg) ^ (PARITY_ODD != 0)) == par_bit;

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == ST_PARITY && tick)
            par_bit <= rx_s;
         parity_err <= frame_end & rx_s & ~par_ok;
      end
   end
`else
   assign par_ok     = 1'b1;
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param with a per-instance result scoreboard.
module tb_serial_rx_param;

   localparam int BC = 16;
`ifdef SERIAL_RX_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   // start edge is first sampled one edge after it is driven
   localparam int LAT = 1 + 2 + 8 + 16 * 9 + 16 * NPAR;

   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
   } exp_t;

   logic       m_clock = 1'b0;
   logic       p_reset;
   logic       rdx0, rdx1, launch0, launch1;
   logic [7:0] data0, data1;
   logic       complete0, frame_err0, parity_err0, busy0;
   logic       complete1, frame_err1, parity_err1, busy1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   t_start0 = 0;
   int   t_done0 = 0;
   logic prev0 = 1'b0;

   always #5 m_clock = ~m_clock;
   always @(posedge m_clock) cyc <= cyc + 1;

   serial_rx_param #(
      .DATA_BITS(8), .BIT_CLKS(BC), .MSB_FIRST(0), .AUTO_REARM(0)
   ) u_lsb (
      .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx0), .launch(launch0),
      .DATA(data0), .complete(complete0), .frame_err(frame_err0),
      .parity_err(parity_err0), .busy(busy0)
   );

   serial_rx_param #(
      .DATA_BITS(8), .BIT_CLKS(BC), .MSB_FIRST(1), .AUTO_REARM(1)
   ) u_msb (
      .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx1), .launch(launch1),
      .DATA(data1), .complete(complete1), .frame_err(frame_err1),
      .parity_err(parity_err1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge m_clock);
      #1;
   endtask

   task automatic drive(input int which, input logic v);
      if (which == 0) rdx0 = v;
      else            rdx1 = v;
      repeat (BC) tick();
   endtask

   task automatic send(input int which, input logic [7:0] d, input bit msb,
                       input bit stop, input bit bad_par);
      exp_t e;
      e.data = d;
      e.kind = !stop ? 3'b010 : (bad_par ? 3'b001 : 3'b100);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
      if (which == 0) t_start0 = cyc;
      drive(which, 1'b0);
      for (int i = 0; i < 8; i++)
         drive(which, msb ? d[7-i] : d[i]);
`ifdef SERIAL_RX_PARITY_EN
      drive(which, (^d) ^ bad_par);
`endif
      drive(which, stop);
      if (which == 0) rdx0 = 1'b1;
      else            rdx1 = 1'b1;
   endtask

   // scoreboard: every result pulse must match the oldest expectation
   always @(negedge m_clock) begin
      exp_t e;
      if (p_reset) begin
         if (prev0 && launch0) check("relaunch_armed", 32'(busy0), 32'd1);
         prev0 = complete0 | frame_err0 | parity_err0;
         if (complete0 | frame_err0 | parity_err0) begin
            t_done0 = cyc;
            if (q0.size() == 0)
               check("lsb_unexpected_pulse",
                     32'({complete0, frame_err0, parity_err0}), 32'd0);
            else begin
               e = q0.pop_front();
               check("lsb_kind", 32'({complete0, frame_err0, parity_err0}),
                     32'(e.kind));
               check("lsb_data", 32'(data0), 32'(e.data));
               check("lsb_busy_at_end", 32'(busy0), 32'd0);
            end
         end
         if (complete1 | frame_err1 | parity_err1) begin
            if (q1.size() == 0)
               check("msb_unexpected_pulse",
                     32'({complete1, frame_err1, parity_err1}), 32'd0);
            else begin
               e = q1.pop_front();
               check("msb_kind", 32'({complete1, frame_err1, parity_err1}),
                     32'(e.kind));
               check("msb_data", 32'(data1), 32'(e.data));
               check("msb_busy_rearm", 32'(busy1), 32'd1);
            end
         end
      end else begin
         prev0 = 1'b0;
      end
   end

   initial begin
      p_reset = 1'b0;
      rdx0 = 1'b1;
      rdx1 = 1'b1;
      launch0 = 1'b0;
      launch1 = 1'b0;
      repeat (3) tick();
      check("rst_data0", 32'(data0), 32'd0);
      check("rst_data1", 32'(data1), 32'd0);
      check("rst_pulses0", 32'({complete0, frame_err0, parity_err0}), 32'd0);
      check("rst_busy0", 32'(busy0), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      p_reset = 1'b1;
      repeat (3) tick();
      check("idle_without_launch", 32'(busy0), 32'd0);

      // basic LSB-first frame and latency
      launch0 = 1'b1;
      tick();
      launch0 = 1'b0;
      tick();
      check("armed_after_launch", 32'(busy0), 32'd1);
      send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      check("latency", 32'(t_done0 - t_start0), 32'(LAT));
      check("data_hold", 32'(data0), 32'hA5);

      // short glitch is a false start
      launch0 = 1'b1;
      tick();
      launch0 = 1'b0;
      rdx0 = 1'b0;
      repeat (4) tick();
      rdx0 = 1'b1;
      repeat (24) tick();
      check("glitch_still_armed", 32'(busy0), 32'd1);
      check("glitch_data_kept", 32'(data0), 32'hA5);
      launch0 = 1'b1;
      send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      launch0 = 1'b0;

      // bad stop bit, already armed from held launch
      send(0, 8'h81, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      check("idle_after_ferr", 32'(busy0), 32'd0);
      check("ferr_data", 32'(data0), 32'h81);

      // reset in the middle of the data bits
      launch0 = 1'b1;
      tick();
      launch0 = 1'b0;
      drive(0, 1'b0);
      rdx0 = 1'b1;
      repeat (40) tick();
      p_reset = 1'b0;
      tick();
      check("midrst_data", 32'(data0), 32'd0);
      check("midrst_busy", 32'(busy0), 32'd0);
      check("midrst_pulses", 32'({complete0, frame_err0, parity_err0}), 32'd0);
      p_reset = 1'b1;
      repeat (3) tick();
      check("postrst_idle", 32'(busy0), 32'd0);
      launch0 = 1'b1;
      tick();
      launch0 = 1'b0;
      send(0, 8'h5A, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();

      // MSB-first with auto re-arm, back-to-back frames
      launch1 = 1'b1;
      tick();
      launch1 = 1'b0;
      send(1, 8'h12, 1'b1, 1'b1, 1'b0);
      send(1, 8'h34, 1'b1, 1'b1, 1'b0);
      repeat (4) tick();
      check("rearm_busy", 32'(busy1), 32'd1);

      // break condition on the auto re-arm receiver
      q1.push_back('{kind: 3'b010, data: 8'h00});
      repeat (10 + NPAR) drive(1, 1'b0);
      rdx1 = 1'b1;
      repeat (30) tick();
      check("break_rearmed", 32'(busy1), 32'd1);
      check("break_data", 32'(data1), 32'd0);

`ifdef SERIAL_RX_PARITY_EN
      launch0 = 1'b1;
      tick();
      launch0 = 1'b0;
      send(0, 8'h07, 1'b0, 1'b1, 1'b1);
      repeat (4) tick();
      launch0 = 1'b1;
      tick();
      launch0 = 1'b0;
      send(0, 8'h07, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      check("parity_ok_data", 32'(data0), 32'h07);
`endif

      repeat (40) tick();
      check("sb0_drained", 32'(q0.size()), 32'd0);
      check("sb1_drained", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
